// File: rtl/irq_arbiter.sv
// ============================================================================
// irq_arbiter : masked fixed-priority interrupt aggregator with claim/EOI regs
// Revision    : 1.0
// ============================================================================
`default_nettype none

module irq_arbiter #(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [29:0]      Addr,
  input  logic             WE,
  input  logic             RE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic             int_req
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  localparam logic [1:0] A_MASK    = 2'd0;
  localparam logic [1:0] A_MODE    = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_CLAIM   = 2'd3;

  localparam int PAD = 32 - N_SRC;

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] prev_q;
  logic [4:0]       isr_id_q, isr_id_d;
  logic [1:0]       state_q, state_d;

  logic [1:0]       sel;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] claim_clr;
  logic [4:0]       winner;
  logic             claim_fire;
  logic             eoi_match;
  logic             unused_bits;

  assign sel         = Addr[1:0];
  assign active      = pending_q & mask_q;
  assign w1c         = (WE && sel == A_PENDING) ? Din[N_SRC-1:0] : '0;
  // A simultaneous write wins over the claim side effect.
  assign claim_fire  = RE && !WE && (sel == A_CLAIM) && (state_q == S_REQ) && (|active);
  assign eoi_match   = WE && (sel == A_CLAIM) && (Din[4:0] == isr_id_q);
  assign unused_bits = ^{Addr[29:2], Din[31:N_SRC]};

  always_comb begin
    winner    = '0;
    claim_clr = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner = 5'(i);
    end
    for (int i = 0; i < N_SRC; i++) begin
      claim_clr[i] = claim_fire && (winner == 5'(i));
    end
  end

  // Edge sources: new rising edge overrides any clear in the same cycle.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i])
        pending_d[i] = (pending_q[i] & ~w1c[i] & ~claim_clr[i]) | (irq_in[i] & ~prev_q[i]);
      else
        pending_d[i] = irq_in[i];
    end
  end

  always_comb begin
    mask_d   = (WE && sel == A_MASK) ? Din[N_SRC-1:0] : mask_q;
    mode_d   = (WE && sel == A_MODE) ? Din[N_SRC-1:0] : mode_q;
    isr_id_d = claim_fire ? winner : isr_id_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q    <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      prev_q    <= '0;
      isr_id_q  <= '0;
    end else begin
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      prev_q    <= irq_in;
      isr_id_q  <= isr_id_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (|active) state_d = S_REQ;
      S_REQ: begin
        if (claim_fire)    state_d = S_SERVICE;
        else if (~|active) state_d = S_IDLE;
      end
      S_SERVICE: if (eoi_match) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    int_req = (state_q == S_REQ);
  end

  always_comb begin
    Dout = '0;
    case (sel)
      A_MASK:    Dout = {{PAD{1'b0}}, mask_q};
      A_MODE:    Dout = {{PAD{1'b0}}, mode_q};
      A_PENDING: Dout = {{PAD{1'b0}}, pending_q};
      A_CLAIM:   Dout = claim_fire ? {1'b1, 26'b0, winner} : {1'b0, 26'b0, isr_id_q};
      default:   Dout = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_arbiter.sv
// ============================================================================
// tb_irq_arbiter : directed + randomized bench with a rule-level reference model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_irq_arbiter;
  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  irq_in = '0;
  logic [29:0]   Addr = '0;
  logic          WE = 1'b0;
  logic          RE = 1'b0;
  logic [31:0]   Din = '0;
  logic [31:0]   Dout;
  logic          int_req;

  int n_tests = 0;
  int n_fail  = 0;

  irq_arbiter #(.N_SRC(N)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .Addr(Addr), .WE(WE),
    .RE(RE), .Din(Din), .Dout(Dout), .int_req(int_req)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = no request, 1 = requesting, 2 = being serviced.
  logic [N-1:0] m_mask = '0, m_mode = '0, m_pend = '0, m_prev = '0;
  int           m_phase = 0;
  int           m_id = 0;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_dout();
    logic [N-1:0] act;
    act = m_pend & m_mask;
    case (Addr[1:0])
      2'd0: return 32'(m_mask);
      2'd1: return 32'(m_mode);
      2'd2: return 32'(m_pend);
      default: begin
        if (RE && !WE && m_phase == 1 && act != 0)
          return 32'h8000_0000 | 32'(lowest(act));
        return 32'(m_id);
      end
    endcase
  endfunction

  always @(negedge reset) begin
    m_mask = '0; m_mode = '0; m_pend = '0; m_prev = '0;
    m_phase = 0; m_id = 0;
  end

  always @(posedge clk) begin
    logic [N-1:0] act, np, nm, nmo;
    int           w, nphase;
    bit           claim_ev, clr;
    if (reset) begin
      act      = m_pend & m_mask;
      w        = lowest(act);
      claim_ev = RE && !WE && Addr[1:0] == 2'd3 && m_phase == 1 && act != 0;
      for (int i = 0; i < N; i++) begin
        clr = (WE && Addr[1:0] == 2'd2 && Din[i]) || (claim_ev && w == i);
        if (m_mode[i]) np[i] = (m_pend[i] && !clr) || (irq_in[i] && !m_prev[i]);
        else           np[i] = irq_in[i];
      end
      nm  = (WE && Addr[1:0] == 2'd0) ? Din[N-1:0] : m_mask;
      nmo = (WE && Addr[1:0] == 2'd1) ? Din[N-1:0] : m_mode;
      nphase = m_phase;
      if (m_phase == 0 && act != 0) nphase = 1;
      else if (m_phase == 1) begin
        if (claim_ev) begin nphase = 2; m_id = w; end
        else if (act == 0) nphase = 0;
      end else if (m_phase == 2 && WE && Addr[1:0] == 2'd3 && int'(Din[4:0]) == m_id)
        nphase = 0;
      m_pend = np; m_mask = nm; m_mode = nmo; m_prev = irq_in; m_phase = nphase;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model int_req", {31'b0, int_req}, {31'b0, m_phase == 1});
    check("model dout", Dout, m_dout());
  end

  task automatic tick();
    @(posedge clk);
    #2;
    WE = 1'b0;
    RE = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = {28'b0, a}; Din = d; WE = 1'b1; RE = 1'b0;
    tick();
  endtask

  task automatic lit(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = {28'b0, a}; RE = 1'b0; WE = 1'b0;
    #1 check(name, Dout, exp);
  endtask

  task automatic chkreq(input string name, input logic exp);
    check(name, {31'b0, int_req}, {31'b0, exp});
  endtask

  task automatic claim(input string name, input logic [31:0] exp);
    Addr = 30'd3; RE = 1'b1; WE = 1'b0;
    #1 check(name, Dout, exp);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chkreq("reset int_req", 1'b0);
    lit("reset mask", 2'd0, 32'h0);

    // Single edge source: latency and claim
    wr(2'd0, 32'h3); wr(2'd1, 32'h3);
    irq_in = 6'b000010; tick(); irq_in = '0;
    chkreq("t1 req early", 1'b0);
    lit("t1 pending", 2'd2, 32'h2);
    tick(); chkreq("t1 req", 1'b1);
    claim("t1 claim", 32'h8000_0001); tick();
    chkreq("t1 req after claim", 1'b0);
    lit("t1 pending cleared", 2'd2, 32'h0);
    tick(); lit("t1 claim in service", 2'd3, 32'h1);
    wr(2'd3, 32'h1);

    // Priority between sources 0 and 3
    wr(2'd0, 32'h9); wr(2'd1, 32'h9);
    irq_in = 6'b001001; tick(); irq_in = '0;
    tick(); chkreq("t2 req", 1'b1);
    claim("t2 claim 0", 32'h8000_0000); tick();
    lit("t2 pending bit3", 2'd2, 32'h8);
    wr(2'd3, 32'h0); chkreq("t2 idle", 1'b0);
    tick(); chkreq("t2 rereq", 1'b1);
    claim("t2 claim 3", 32'h8000_0003); tick();
    wr(2'd3, 32'h3);

    // Level mode
    wr(2'd1, 32'h0); wr(2'd0, 32'h1);
    irq_in = 6'b000001; tick();
    lit("t3 pending", 2'd2, 32'h1);
    tick(); chkreq("t3 req", 1'b1);
    claim("t3 claim", 32'h8000_0000); tick();
    lit("t3 pending held", 2'd2, 32'h1);
    wr(2'd3, 32'h0);
    tick(); chkreq("t3 rereq", 1'b1);
    irq_in = '0; tick();
    lit("t3 pending drop", 2'd2, 32'h0);
    tick(); chkreq("t3 req gone", 1'b0);
    tick(); tick(); chkreq("t3 stays quiet", 1'b0);

    // Mask retract
    wr(2'd1, 32'h4); wr(2'd0, 32'h4);
    irq_in = 6'b000100; tick(); irq_in = '0;
    tick(); chkreq("t4 req", 1'b1);
    wr(2'd0, 32'h0); chkreq("t4 req one more", 1'b1);
    tick(); chkreq("t4 retracted", 1'b0);
    lit("t4 pending kept", 2'd2, 32'h4);
    wr(2'd0, 32'h4); tick(); chkreq("t4 restored", 1'b1);
    claim("t4 claim", 32'h8000_0002); tick();
    wr(2'd3, 32'h2);

    // Wrong EOI id is ignored
    wr(2'd1, 32'h2); wr(2'd0, 32'h2);
    irq_in = 6'b000010; tick(); irq_in = '0;
    tick(); claim("t5 claim", 32'h8000_0001); tick();
    wr(2'd3, 32'h2); chkreq("t5 after bad eoi", 1'b0);
    lit("t5 id", 2'd3, 32'h1);
    irq_in = 6'b000010; tick(); irq_in = '0;
    tick(); tick(); chkreq("t5 still service", 1'b0);
    wr(2'd3, 32'h1); tick(); chkreq("t5 rereq", 1'b1);
    claim("t5 claim again", 32'h8000_0001); tick();
    wr(2'd3, 32'h1);

    // Async reset in service
    irq_in = 6'b000010; tick(); irq_in = '0;
    tick(); claim("t6 claim", 32'h8000_0001); tick();
    #1 reset = 1'b0;
    #1 chkreq("t6 async int_req", 1'b0);
    lit("t6 mask", 2'd0, 32'h0);
    lit("t6 mode", 2'd1, 32'h0);
    @(negedge clk); #1;
    lit("t6 pending", 2'd2, 32'h0);
    lit("t6 claim", 2'd3, 32'h0);
    tick(); reset = 1'b1;

    // Same-cycle W1C and rising edge: set wins
    wr(2'd0, 32'h10); wr(2'd1, 32'h10);
    irq_in = 6'b010000; Addr = 30'd2; Din = 32'h10; WE = 1'b1; tick(); irq_in = '0;
    lit("t6 set wins", 2'd2, 32'h10);
    tick(); tick();
    claim("t6 claim 4", 32'h8000_0004); tick();
    wr(2'd3, 32'h4);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
      Addr = 30'($urandom);
      WE   = ($urandom_range(0, 3) == 0);
      RE   = ($urandom_range(0, 2) == 0);
      Din  = $urandom;
      if ($urandom_range(0, 1) == 1) Din[4:0] = 5'($urandom_range(0, N - 1));
      if ($urandom_range(0, 499) == 0) begin
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
      end
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
- Interrupt aggregation stage directly downstream of the system timers and other IRQ-producing devices.
- Collects N device IRQ lines and latches them into a pending register, with edge or level mode per source.
- Applies a mask and fixed priority, then drives a single interrupt request toward CP0.
- CPU software claims the winning source through a memory-mapped register and retires it with an end-of-interrupt (EOI) write, using the same Addr/WE/Din/Dout register convention as the timers.

Parameters:
- N_SRC, 6: number of interrupt sources, 1..31; source 0 has the highest priority.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; all state cleared immediately while low.
- irq_in  input  N_SRC  device IRQ lines (timer IRQ outputs etc.), synchronous to clk.
- Addr  input  30  word address bits [31:2]; Addr[3:2] selects the register.
- WE  input  1  register write strobe.
- RE  input  1  register read strobe; needed only for the CLAIM side effect.
- Din  input  32  write data.
- Dout  output  32  read data, combinational from Addr[3:2].
- int_req  output  1  interrupt request to CP0 HWInt.

Behaviour:
- Registers, selected by Addr[3:2]:
  - 0 MASK: R/W, N_SRC bits; 1 = source enabled.
  - 1 MODE: R/W, N_SRC bits; 1 = edge, 0 = level.
  - 2 PENDING: R; a write of 1 clears that bit (W1C).
  - 3 CLAIM/EOI: read = claim, write = EOI.
- All unused upper bits read 0.
- Reset values: MASK=0, MODE=0, PENDING=0, prev_irq=0, in-service id=0, state=IDLE, int_req=0.
- Edge capture: prev_irq registers irq_in every cycle. In edge mode, PENDING[i] is set on a rising edge (irq_in[i] & ~prev_irq[i]).
- Level capture: in level mode, PENDING[i] is loaded with irq_in[i] every cycle. W1C has no lasting effect while the line stays high.
- Set and W1C clear on the same bit in the same cycle: set wins.
- active = PENDING & MASK. winner = lowest index set in active.
- State machine:
  - IDLE: if active != 0, go to REQ next cycle.
  - REQ: int_req = 1. If active becomes 0 (mask write or clear), return to IDLE next cycle and drop int_req.
  - REQ to SERVICE: on RE=1 with Addr[3:2]=3:
    - Dout = {1'b1, 26'b0, winner[4:0]} in that cycle.
    - In-service id <= winner.
    - If the winner is edge mode, PENDING[winner] is cleared.
    - Next state is SERVICE, and int_req falls the next cycle.
  - SERVICE: int_req = 0. New edges keep latching into PENDING.
  - SERVICE to IDLE: on WE with Addr[3:2]=3 and Din[4:0] == in-service id. An EOI with a mismatched id is ignored.
  - From IDLE after EOI, a still-pending source re-requests one cycle later.
- CLAIM read in IDLE or SERVICE returns {1'b0, 26'b0, in-service id} with no side effect.
- EOI write outside SERVICE is ignored.
- WE and RE asserted together: the write is performed and the claim side effect is suppressed.
- Dout is valid regardless of RE; the PENDING read shows the current register value.
- Latency: a rising edge on irq_in at cycle t gives PENDING set at t+1, REQ at t+2, int_req high at t+2 (registered from state).
- Reset low mid-SERVICE: returns to IDLE and clears everything asynchronously. After release, sources must re-assert (edge) or still be high (level) to be seen.

Test Plan:
- Reset, MASK=6'b000011, MODE=6'b000011. Pulse irq_in[1] one cycle -> PENDING=2 next cycle; int_req=1 one cycle after that; CLAIM read returns 0x80000001; int_req=0 the following cycle; PENDING=0.
- Priority: edge sources 0 and 3 enabled, both pulsed in the same cycle -> claim returns id 0, PENDING still has bit 3. EOI with Din=0 -> IDLE, then int_req=1 again; second claim returns 0x80000003.
- Level mode: MODE=0, MASK=1, irq_in[0] held high -> claim returns 0x80000000 and PENDING[0] stays 1. EOI while still high -> re-request. Drop irq_in[0] -> PENDING=0 and no further int_req.
- Mask retract: source 2 pending in REQ, write MASK=0 -> IDLE one cycle later, int_req=0, PENDING[2] still 1. Restore MASK -> int_req returns.
- Wrong EOI: in SERVICE with id 1, write EOI Din=2 -> state stays SERVICE, int_req stays 0. A later EOI Din=1 -> IDLE.
- Async reset: assert reset low in SERVICE between clock edges -> int_req=0 and all registers 0 immediately. Same-cycle W1C and edge on bit 4 -> PENDING[4]=1.
